key_device: RTL

KEY_DEVICE -- requirements
Module: key_device

---
 rtl/key_device.sv | 62 ++++++
 1 files changed

// File: rtl/key_device.sv
// key_device: bus-mapped 4-key input (KDATA at BASE, KCTRL at BASE+4) with RDY/OVR status and IRQ.
// Define KEY_DEBOUNCE_EN to add per-key debounce counters; otherwise keys are only synchronized.
module key_device #(
  parameter int BITS = 32,
  parameter logic [BITS-1:0] BASE = 32'hF0000010,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [3:0]      KEY,
  input  logic [BITS-1:0] ABUS,
  inout  wire  [BITS-1:0] DBUS,
  input  logic            WE,
  output logic            IRQ
);
  localparam logic [BITS-1:0] CTRL = BASE + BITS'(4);
  logic [3:0] s1, s2, kstate, kstate_n;
  logic rdy, ovr, ie, sel_data, sel_ctrl, changed, clr_rdy, wr_ctrl;
  logic [BITS-1:0] rd_data;
  assign sel_data = ABUS == BASE;
  assign sel_ctrl = ABUS == CTRL;
  assign wr_ctrl = WE & sel_ctrl;
  assign clr_rdy = (~WE & sel_data) | (wr_ctrl & ~DBUS[0]);
  assign changed = kstate_n != kstate;
  assign rd_data = sel_data ? {{(BITS-4){1'b0}}, kstate} : {{(BITS-9){1'b0}}, ie, 6'b0, ovr, rdy};
  assign DBUS = (~WE & (sel_data | sel_ctrl)) ? rd_data : 'z;
  assign IRQ = rdy & ie;
`ifdef KEY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt [4];
  logic [3:0] hit;
  always_comb begin
    hit = '0;
    for (int k = 0; k < 4; k++) hit[k] = cnt[k] == LAST;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) cnt <= '{default: '0};
    else for (int k = 0; k < 4; k++) cnt[k] <= (s2[k] == kstate[k] || hit[k]) ? '0 : cnt[k] + 1'b1;
  // a key flips only after its synchronized value has disagreed for DEBOUNCE_CYCLES evaluations
  assign kstate_n = kstate ^ ((s2 ^ kstate) & hit);
`else
  assign kstate_n = s2;
`endif
  // status set beats any clear issued in the same cycle
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      s1 <= '0;
      s2 <= '0;
      kstate <= '0;
      rdy <= 1'b0;
      ovr <= 1'b0;
      ie <= 1'b0;
    end else begin
      s1 <= ~KEY;
      s2 <= s1;
      kstate <= kstate_n;
      rdy <= changed | (rdy & ~clr_rdy);
      ovr <= (changed & rdy & ~clr_rdy) | (ovr & ~(wr_ctrl & ~DBUS[1]));
      ie <= wr_ctrl ? DBUS[8] : ie;
    end
endmodule
